imem_boot_controller: RTL



---
 rtl/cpu_pkg.sv | 19 +
 rtl/imem_byte_packer.sv | 53 +++++
 rtl/imem_boot_controller.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the program-memory boot controller.
// State encoding plus word/address geometry used by the controller and byte packer.
package cpu_pkg;

    localparam int INSTR_WIDTH    = 32;
    localparam int ADDR_WIDTH     = 12;
    localparam int MEM_DEPTH      = 4096;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [7:0] OPC_HALT = 8'hFF;

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_LOAD   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RUN    = 2'd3
    } state_e;

endpackage : cpu_pkg

// File: rtl/imem_byte_packer.sv
// Collects loader bytes big-endian into one instruction word.
// word_valid pulses in the cycle the final byte of a word is accepted.
module imem_byte_packer
    import cpu_pkg::*;
(
    input  logic                   clk_70_mhz,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   byte_accept,
    input  logic [7:0]             byte_data,
    output logic                   word_valid,
    output logic [INSTR_WIDTH-1:0] word
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [INSTR_WIDTH-1:0] shift_q, shift_d;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        word_valid = 1'b0;
        if (clear) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_accept) begin
            // Shifting left puts the first byte of the word in the top lane.
            shift_d = {shift_q[INSTR_WIDTH-9:0], byte_data};
            if (cnt_q == CNT_W'(BYTES_PER_WORD - 1)) begin
                cnt_d      = '0;
                word_valid = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_70_mhz) begin
        if (rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    assign word = shift_q;

endmodule : imem_byte_packer

// File: rtl/imem_boot_controller.sv
// Arbitrates the single-port program memory between the byte-stream boot loader
// and the CPU fetch path; stalls the CPU until a load finishes or a run is requested.
module imem_boot_controller #(
    parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
    parameter int MEM_DEPTH   = cpu_pkg::MEM_DEPTH,
    parameter int ADDR_WIDTH  = cpu_pkg::ADDR_WIDTH
) (
    input  logic                   clk_70_mhz,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic [ADDR_WIDTH-1:0]  load_base,
    input  logic [ADDR_WIDTH:0]    load_len,
    input  logic                   run_start,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    input  logic [ADDR_WIDTH-1:0]  fetch_addr,
    output logic [INSTR_WIDTH-1:0] fetch_instr,
    output logic                   cpu_stall,
    input  logic                   cpu_halt,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [INSTR_WIDTH-1:0] mem_wdata,
    output logic                   mem_we,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic                   load_busy,
    output logic                   load_done
);

    import cpu_pkg::state_e;
    import cpu_pkg::ST_HALTED;
    import cpu_pkg::ST_LOAD;
    import cpu_pkg::ST_WRITE;
    import cpu_pkg::ST_RUN;

    localparam int LEN_W = ADDR_WIDTH + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [LEN_W-1:0]      words_left_q, words_left_d;
    logic                  load_done_q, load_done_d;

    logic                   pack_clear;
    logic                   byte_accept;
    logic                   word_valid;
    logic [INSTR_WIDTH-1:0] packed_word;
    logic [LEN_W-1:0]       len_clamped;
    logic                   start_load;

    // Kept outside the FSM block so the accept path does not loop back through it.
    assign byte_ready  = (state_q == ST_LOAD);
    assign byte_accept = byte_valid && byte_ready;
    assign load_done   = load_done_q;

    assign len_clamped = (load_len > LEN_W'(MEM_DEPTH)) ? LEN_W'(MEM_DEPTH) : load_len;

    imem_byte_packer u_packer (
        .clk_70_mhz  (clk_70_mhz),
        .rst         (rst),
        .clear       (pack_clear),
        .byte_accept (byte_accept),
        .byte_data   (byte_data),
        .word_valid  (word_valid),
        .word        (packed_word)
    );

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        words_left_d = words_left_q;
        load_done_d  = 1'b0;
        pack_clear   = 1'b0;
        start_load   = 1'b0;
        cpu_stall    = 1'b1;
        fetch_instr  = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_we       = 1'b0;
        load_busy    = 1'b0;

        unique case (state_q)
            ST_HALTED: begin
                if (load_start) begin
                    start_load = 1'b1;
                end else if (run_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                load_busy = 1'b1;
                mem_addr  = wptr_q;
                if (word_valid) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                load_busy    = 1'b1;
                mem_we       = 1'b1;
                mem_addr     = wptr_q;
                mem_wdata    = packed_word;
                wptr_d       = wptr_q + ADDR_WIDTH'(1);
                words_left_d = words_left_q - LEN_W'(1);
                if (words_left_q == LEN_W'(1)) begin
                    state_d     = ST_RUN;
                    load_done_d = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                cpu_stall   = 1'b0;
                mem_addr    = fetch_addr;
                fetch_instr = mem_rdata;
                if (load_start) begin
                    start_load = 1'b1;
                end else if (cpu_halt) begin
                    state_d = ST_HALTED;
                end
            end
            default: state_d = ST_HALTED;
        endcase

        // A zero-length load completes immediately without touching memory.
        if (start_load) begin
            pack_clear   = 1'b1;
            wptr_d       = load_base;
            words_left_d = len_clamped;
            if (len_clamped == '0) begin
                state_d     = ST_RUN;
                load_done_d = 1'b1;
            end else begin
                state_d = ST_LOAD;
            end
        end
    end

    always_ff @(posedge clk_70_mhz) begin
        if (rst) begin
            state_q      <= ST_HALTED;
            wptr_q       <= '0;
            words_left_q <= '0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            words_left_q <= words_left_d;
            load_done_q  <= load_done_d;
        end
    end

endmodule : imem_boot_controller
